// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: pin sync/deglitch, 11-bit frame deserialiser,
// E0/F0/E1 prefix folding and a small key-event FIFO.
module ps2_scan_receiver #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       key_ack,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       frame_error,
    output logic       overflow
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          ps2_clk_s, ps2_dat_s;
    logic          filt_clk, filt_flip, fall;
    logic [FW-1:0] filt_cnt;
    state_t        state, state_nxt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic [TW-1:0] tick_cnt;
    logic          last_bit, frame_ok, timeout;
    logic          byte_strobe;
    logic [7:0]    rx_byte;
    logic          ext_flag, rel_flag, ext_nxt, rel_nxt;
    logic [2:0]    skip_cnt, skip_nxt;
    logic          push_req, dec_err;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en;
    logic [9:0]    head;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
        end
    end

    assign ps2_clk_s = clk_sync[1];
    assign ps2_dat_s = dat_sync[1];

    // The filtered level flips on the FILTER_LEN-th consecutive disagreeing sample.
    assign filt_flip = clk_en && (ps2_clk_s != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_clk;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_en) begin
            if (ps2_clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_flip) begin
                filt_clk <= ps2_clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign last_bit = fall && (state == SHIFT) && (bit_cnt == 4'd10);
    assign frame_ok = (^shreg) && ps2_dat_s;
    assign timeout  = clk_en && (state == SHIFT) && !fall && (tick_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall && !ps2_dat_s) state_nxt = SHIFT;
            SHIFT:   if (last_bit || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            tick_cnt    <= '0;
            byte_strobe <= 1'b0;
            rx_byte     <= '0;
        end else if (clk_en) begin
            byte_strobe <= last_bit && frame_ok;
            if (last_bit) rx_byte <= shreg[7:0];
            if (fall) begin
                tick_cnt <= '0;
                if (state == IDLE) begin
                    bit_cnt <= 4'd1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {ps2_dat_s, shreg[8:1]};
                end
            end else if (tick_cnt != TW'(TIMEOUT)) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ext_nxt  = ext_flag;
        rel_nxt  = rel_flag;
        skip_nxt = skip_cnt;
        push_req = 1'b0;
        dec_err  = 1'b0;
        if (byte_strobe) begin
            if (skip_cnt != '0) begin
                skip_nxt = skip_cnt - 3'd1;
            end else begin
                case (rx_byte)
                    8'hE0: ext_nxt = 1'b1;
                    8'hF0: rel_nxt = 1'b1;
                    8'hE1: begin
                        skip_nxt = 3'd7;
                        ext_nxt  = 1'b0;
                        rel_nxt  = 1'b0;
                    end
                    8'h00, 8'hFF: begin
                        dec_err = 1'b1;
                        ext_nxt = 1'b0;
                        rel_nxt = 1'b0;
                    end
                    default: begin
                        push_req = 1'b1;
                        ext_nxt  = 1'b0;
                        rel_nxt  = 1'b0;
                    end
                endcase
            end
        end
        if (timeout) begin
            ext_nxt = 1'b0;
            rel_nxt = 1'b0;
        end
    end

    assign full  = (count == FULL_CNT);
    assign pop   = clk_en && key_valid && key_ack;
    assign wr_en = clk_en && push_req && (!full || pop);

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            ext_flag    <= 1'b0;
            rel_flag    <= 1'b0;
            skip_cnt    <= '0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else if (clk_en) begin
            ext_flag    <= ext_nxt;
            rel_flag    <= rel_nxt;
            skip_cnt    <= skip_nxt;
            frame_error <= (last_bit && !frame_ok) || timeout || dec_err;
            overflow    <= push_req && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {ext_flag, rel_flag, rx_byte};
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head fields are forced to zero while empty so no stale entry is exposed.
    assign head         = mem[rd_ptr];
    assign key_valid    = (count != '0);
    assign key_code     = key_valid ? head[7:0] : '0;
    assign key_release  = key_valid && head[8];
    assign key_extended = key_valid && head[9];

endmodule
